// File: rtl/weight_tile_loader_if.sv
// weight_tile_loader_if: start/dims, weight-memory read port and tile handshake of the loader
interface weight_tile_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_SIZE  = 32,
    parameter int ADDR_WIDTH = 24
) ();
    logic                                       start;
    logic [ADDR_WIDTH-1:0]                      base_addr;
    logic [9:0]                                 rows;
    logic [9:0]                                 cols;
    logic                                       mem_en;
    logic [ADDR_WIDTH-1:0]                      mem_addr;
    logic signed [DATA_WIDTH-1:0]               mem_rdata;
    logic                                       w_valid;
    logic                                       w_ready;
    logic signed [0:TILE_SIZE-1][DATA_WIDTH-1:0] w_tile_row_out;
    logic                                       busy;
    logic                                       done;
    modport master (
        input  start, base_addr, rows, cols, mem_rdata, w_ready,
        output mem_en, mem_addr, w_valid, w_tile_row_out, busy, done
    );
    modport slave (
        output start, base_addr, rows, cols, mem_rdata, w_ready,
        input  mem_en, mem_addr, w_valid, w_tile_row_out, busy, done
    );
endinterface

// File: rtl/weight_tile_loader.sv
// weight_tile_loader: streams a row-major weight matrix from memory as zero-padded tiles through a 2-deep buffer FIFO
module weight_tile_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_SIZE  = 32,
    parameter int ADDR_WIDTH = 24
) (
    input logic clk,
    input logic rst,
    weight_tile_loader_if.master bus
);
    localparam int LW = TILE_SIZE > 1 ? $clog2(TILE_SIZE) : 1;
    typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [9:0]            rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
    logic [LW-1:0]         lane_q, lane_d, pend_lane_q, pend_lane_d;
    logic                  wr_q, wr_d, rd_q, rd_d;
    logic                  pend_q, pend_d, pend_buf_q, pend_buf_d, pend_last_q, pend_last_d;
    logic                  done_q, done_d;
    logic [1:0]            full_q, full_d;
    logic [DATA_WIDTH-1:0] buf_q [2][TILE_SIZE];
    logic [DATA_WIDTH-1:0] buf_d [2][TILE_SIZE];
    logic                  xfer, blocked, issue, last_col, last_row, tile_end, frees_wr;
    always_comb begin
        xfer     = full_q[rd_q] && bus.w_ready;
        blocked  = lane_q == '0 && full_q[wr_q];
        frees_wr = xfer && rd_q == wr_q;
        issue    = state_q == FETCH && !blocked;
        last_col = col_q == cols_q - 10'd1;
        last_row = row_q == rows_q - 10'd1;
        tile_end = last_col || lane_q == LW'(TILE_SIZE - 1);
        state_d     = state_q;
        addr_d      = addr_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        row_d       = row_q;
        col_d       = col_q;
        lane_d      = lane_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        full_d      = full_q;
        done_d      = 1'b0;
        pend_d      = issue;
        pend_buf_d  = wr_q;
        pend_lane_d = lane_q;
        pend_last_d = tile_end;
        buf_d       = buf_q;
        // a fresh tile starts from all-zero lanes so padding needs no reads
        if (issue && lane_q == '0)
            for (int i = 0; i < TILE_SIZE; i++) buf_d[wr_q][i] = '0;
        if (pend_q) begin
            buf_d[pend_buf_q][pend_lane_q] = bus.mem_rdata;
            if (pend_last_q) full_d[pend_buf_q] = 1'b1;
        end
        if (xfer) begin
            full_d[rd_q] = 1'b0;
            rd_d         = !rd_q;
        end
        if (issue) begin
            addr_d = addr_q + 1'b1;
            lane_d = tile_end ? '0 : lane_q + 1'b1;
            col_d  = last_col ? '0 : col_q + 10'd1;
            row_d  = last_col ? row_q + 10'd1 : row_q;
            wr_d   = tile_end ? !wr_q : wr_q;
        end
        case (state_q)
            IDLE: if (bus.start) begin
                if (bus.rows == '0 || bus.cols == '0) done_d = 1'b1;
                else begin
                    state_d = FETCH;
                    addr_d  = bus.base_addr;
                    rows_d  = bus.rows;
                    cols_d  = bus.cols;
                    row_d   = '0;
                    col_d   = '0;
                    lane_d  = '0;
                end
            end
            FETCH: state_d = issue && last_col && last_row ? DRAIN :
                             blocked && !frees_wr ? STALL : FETCH;
            STALL: state_d = !full_q[wr_q] || frees_wr ? FETCH : STALL;
            DRAIN: if (xfer && !pend_q && !full_q[!rd_q]) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
    end
    always_comb begin
        bus.mem_en   = issue;
        bus.mem_addr = addr_q;
        bus.w_valid  = full_q[rd_q];
        bus.busy     = state_q != IDLE;
        bus.done     = done_q;
        for (int i = 0; i < TILE_SIZE; i++) bus.w_tile_row_out[i] = buf_q[rd_q][i];
    end
    always_ff @(posedge clk) begin
        buf_q       <= buf_d;
        addr_q      <= addr_d;
        rows_q      <= rows_d;
        cols_q      <= cols_d;
        row_q       <= row_d;
        col_q       <= col_d;
        lane_q      <= lane_d;
        pend_buf_q  <= pend_buf_d;
        pend_lane_q <= pend_lane_d;
        pend_last_q <= pend_last_d;
        if (rst) begin
            state_q <= IDLE;
            full_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: tb/tb_weight_tile_loader.sv
// tb_weight_tile_loader: vector table plus corner sequences, scoreboarded reads and tiles
module tb_weight_tile_loader;
    localparam int DW = 8;
    localparam int TS = 32;
    localparam int AW = 24;
    typedef logic [0:TS-1][DW-1:0] tile_t;
    typedef struct {
        int rows;
        int cols;
        int base;
        bit rnd;
        bit contig;
        int reads;
        int tiles;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    weight_tile_loader_if bus ();
    weight_tile_loader dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) bus.mem_rdata <= bus.mem_en ? bus.mem_addr[7:0] : 8'h00;
    logic [AW-1:0] exp_addr[$];
    tile_t         exp_tiles[$];
    int total = 0, bad = 0;
    int cyc = 0, en_cnt = 0, x_cnt = 0, done_cnt = 0;
    int first_en = -1, last_en = 0, last_x = 0, done_cyc = 0;
    logic s_en, s_valid, s_busy, s_done;
    tile_t s_tile;
    vec_t vecs[7];
    task automatic chk(input string n, input logic [TS*DW-1:0] act, input logic [TS*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_en = bus.mem_en;
        s_valid = bus.w_valid;
        s_busy = bus.busy;
        s_done = bus.done;
        s_tile = bus.w_tile_row_out;
        if (s_en) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            chk("read_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) chk("read_addr", bus.mem_addr, exp_addr.pop_front());
        end
        if (s_valid && bus.w_ready) begin
            x_cnt++;
            last_x = cyc;
            chk("tile_expected", exp_tiles.size() != 0, 1);
            if (exp_tiles.size() != 0) chk("tile", s_tile, exp_tiles.pop_front());
        end
        if (s_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", s_busy, 0);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic push_load(input int r, input int c, input logic [AW-1:0] b);
        logic [AW-1:0] a;
        tile_t tl;
        for (int rr = 0; rr < r; rr++)
            for (int t = 0; t < (c + TS - 1) / TS; t++) begin
                tl = '0;
                for (int i = 0; i < TS; i++)
                    if (t * TS + i < c) begin
                        a = b + AW'(rr * c + t * TS + i);
                        tl[i] = a[7:0];
                        exp_addr.push_back(a);
                    end
                exp_tiles.push_back(tl);
            end
    endtask
    task automatic begin_load(input int r, input int c, input logic [AW-1:0] b,
                              output int en0, output int x0, output int d0, output int st);
        push_load(r, c, b);
        en0 = en_cnt;
        x0 = x_cnt;
        d0 = done_cnt;
        first_en = -1;
        bus.rows = 10'(r);
        bus.cols = 10'(c);
        bus.base_addr = b;
        bus.start = 1'b1;
        tick();
        st = cyc;
        bus.start = 1'b0;
    endtask
    task automatic finish_load(input int en0, input int x0, input int d0, input int st,
                               input int reads, input int tiles, input bit rnd, input bit contig);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
        bus.w_ready = 1'b1;
        repeat (3) tick();
        chk("done_once", done_cnt - d0, 1);
        chk("reads", en_cnt - en0, reads);
        chk("tiles", x_cnt - x0, tiles);
        chk("addr_left", exp_addr.size(), 0);
        chk("tiles_left", exp_tiles.size(), 0);
        if (tiles > 0) chk("done_after_xfer", done_cyc - last_x, 1);
        else chk("done_after_start", done_cyc - st, 1);
        if (contig) chk("no_bubbles", last_en - first_en + 1, reads);
    endtask
    initial begin
        int en0, x0, d0, st;
        vecs[0] = '{2, 32, 'h100, 1'b0, 1'b1, 64, 2};
        vecs[1] = '{1, 40, 'h200, 1'b0, 1'b1, 40, 2};
        vecs[2] = '{3, 5, 'hFFFFFE, 1'b1, 1'b0, 15, 3};
        vecs[3] = '{0, 16, 'h300, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{2, 64, 'h7F0, 1'b1, 1'b0, 128, 4};
        vecs[5] = '{3, 1, 'h10, 1'b0, 1'b0, 3, 3};
        vecs[6] = '{5, 0, 'h10, 1'b0, 1'b0, 0, 0};
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.rows = '0;
        bus.cols = '0;
        bus.w_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_mem_en", s_en, 0);
        chk("rst_w_valid", s_valid, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        for (int k = 0; k < 7; k++) begin
            bus.w_ready = 1'b1;
            begin_load(vecs[k].rows, vecs[k].cols, AW'(vecs[k].base), en0, x0, d0, st);
            finish_load(en0, x0, d0, st, vecs[k].reads, vecs[k].tiles, vecs[k].rnd, vecs[k].contig);
        end
        // consumer stalled: both buffers fill, then fetch must stop with tile0 held
        bus.w_ready = 1'b0;
        begin_load(4, 32, 'h400, en0, x0, d0, st);
        repeat (100) tick();
        chk("bp_tile0_early", s_tile, exp_tiles[0]);
        repeat (100) tick();
        chk("bp_reads", en_cnt - en0, 64);
        chk("bp_valid", s_valid, 1);
        chk("bp_tile0_late", s_tile, exp_tiles[0]);
        chk("bp_no_xfer", x_cnt - x0, 0);
        finish_load(en0, x0, d0, st, 128, 4, 1'b0, 1'b0);
        // reset while the second tile is being fetched
        bus.w_ready = 1'b1;
        begin_load(2, 32, 'h100, en0, x0, d0, st);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_addr.delete();
        exp_tiles.delete();
        tick();
        chk("mid_rst_mem_en", s_en, 0);
        chk("mid_rst_w_valid", s_valid, 0);
        chk("mid_rst_busy", s_busy, 0);
        begin_load(1, 8, 'h50, en0, x0, d0, st);
        finish_load(en0, x0, d0, st, 8, 1, 1'b0, 1'b1);
        // a second start during a load must leave the first load untouched
        begin_load(1, 40, 'h600, en0, x0, d0, st);
        repeat (5) tick();
        bus.rows = 10'd3;
        bus.cols = 10'd10;
        bus.base_addr = 'h900;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        finish_load(en0, x0, d0, st, 40, 2, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/weight_tile_loader.md
WEIGHT_TILE_LOADER -- requirements
Module: weight_tile_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, weight element width.
REQ-002 SHALL have parameter TILE_SIZE, default 32, elements per tile.
REQ-003 SHALL have parameter ADDR_WIDTH, default 24, weight memory byte-address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a matrix load.
REQ-007 base_addr  input  ADDR_WIDTH  address of W[0][0], sampled on accepted start.
REQ-008 rows  input  10  matrix rows, sampled on accepted start.
REQ-009 cols  input  10  matrix columns, sampled on accepted start.
REQ-010 mem_en  output  1  read request to weight memory.
REQ-011 mem_addr  output  ADDR_WIDTH  read byte address, valid while mem_en=1.
REQ-012 mem_rdata  input  DATA_WIDTH  signed read data, valid exactly one cycle after mem_en.
REQ-013 w_valid  output  1  tile available to the GEMV consumer.
REQ-014 w_ready  input  1  consumer accepts the tile.
REQ-015 w_tile_row_out  output  signed DATA_WIDTH x [0:TILE_SIZE-1]  tile lanes.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse after final tile transfer.

Function
REQ-018 Weights SHALL be row-major and packed: W[r][c] at base_addr + r*cols + c, modulo 2^ADDR_WIDTH.
REQ-019 Per row r, tiles t = 0..ceil(cols/TILE_SIZE)-1 SHALL be emitted in order r-major then t; total rows*ceil(cols/TILE_SIZE) tiles.
REQ-020 Lane i of tile (r,t) SHALL be W[r][t*TILE_SIZE+i] when t*TILE_SIZE+i < cols, else zero.
REQ-021 Zero-padded lanes SHALL issue no memory read; one mem_en per real element, addresses strictly ascending.
REQ-022 Fetch SHALL issue at most one read per cycle; data returned in cycle n+1 written to its lane of the fill buffer.
REQ-023 Loader SHALL contain two tile buffers used as a 2-entry FIFO; fetch fills one while the other is presented.
REQ-024 Fetch FSM states: IDLE, FETCH, STALL, DRAIN; IDLE->FETCH on start (dims nonzero); FETCH->STALL when both buffers full; STALL->FETCH when one frees; FETCH->DRAIN after last element requested; DRAIN->IDLE after final transfer, with done pulse.
REQ-025 A buffer becomes full the cycle after its last real element (or, for a tile with no pending read, immediately) is written; a buffer freed by transfer in cycle n SHALL be refillable from cycle n+1.
REQ-026 Transfer SHALL occur on a cycle with w_valid=1 and w_ready=1; w_valid SHALL be high whenever the FIFO holds a full tile.
REQ-027 w_tile_row_out SHALL show the oldest full buffer and SHALL stay stable while w_valid=1 and w_ready=0.
REQ-028 With w_ready held high, sustained throughput SHALL be one element read per cycle with no bubbles between tiles.
REQ-029 done SHALL pulse the cycle after the final transfer; busy SHALL fall in the same cycle.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 rows=0 or cols=0: no mem_en, no w_valid; done pulses one cycle after start.

Reset
REQ-032 On rst: mem_en=0, w_valid=0, busy=0, done=0, both buffers empty, FSM IDLE, from the next edge, including mid-load; in-flight read data discarded.
REQ-033 Buffer contents and mem_addr need no reset value.

Verification
REQ-034 rows=2, cols=32, base=0x100, mem[a]=a[7:0], w_ready=1 -> 64 reads 0x100..0x13F; tile0 lanes 0x00..0x1F, tile1 0x20..0x3F; done once.
REQ-035 rows=1, cols=40 -> 40 reads; tile1 lanes 0..7 = mem[base+32..base+39], lanes 8..31 = 0.
REQ-036 rows=4, cols=32, w_ready=0 for 200 cycles -> exactly 64 mem_en then none, w_valid stable with tile0; on release all 4 tiles in order.
REQ-037 rows=0, cols=16 -> done one cycle after start, no mem_en, no w_valid.
REQ-038 rst during tile1 fetch -> next cycle mem_en=0, w_valid=0, busy=0; new start with rows=1, cols=8 yields one correct tile.
REQ-039 second start during load -> ignored; tile count and addresses match first load only.
